// File: rtl/decoder_scan.sv
// Registered address decoder with a sequential scan mode that walks every
// select line in turn (e.g. to clear a register file one entry per cycle).
module decoder_scan #(
    parameter int ADDR_W    = 5,
    parameter int ZERO_MASK = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [ADDR_W-1:0]    IN,
    input  logic                 EN,
    input  logic                 CLR_START,
    output logic [2**ADDR_W-1:0] OUT,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int OUT_W = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] FIRST = (ZERO_MASK != 0) ? ADDR_W'(1) : ADDR_W'(0);
    localparam logic [ADDR_W-1:0] LAST  = '1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [ADDR_W-1:0]   cnt_nxt;
    logic [OUT_W-1:0]    out_p1;
    logic                busy_p1;
    logic                done_p1;

    function automatic logic [OUT_W-1:0] onehot(input logic [ADDR_W-1:0] idx);
        logic [OUT_W-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    // Index 0 is suppressed when it is the hardwired-zero register.
    function automatic logic [OUT_W-1:0] decode(input logic [ADDR_W-1:0] idx,
                                                 input logic              en);
        if (!en || (ZERO_MASK != 0 && idx == '0))
            return '0;
        return onehot(idx);
    endfunction

    assign cnt_nxt = cnt + 1'b1;

    // Stage p1: state, counter and all outputs are registered together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            out_p1  <= '0;
            busy_p1 <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_p1 <= 1'b0;
                    if (CLR_START) begin
                        state   <= SCAN;
                        cnt     <= FIRST;
                        out_p1  <= onehot(FIRST);
                        busy_p1 <= 1'b1;
                    end else begin
                        out_p1  <= decode(IN, EN);
                    end
                end
                SCAN: begin
                    if (cnt == LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        out_p1  <= '0;
                        busy_p1 <= 1'b0;
                        done_p1 <= 1'b1;
                    end else begin
                        cnt     <= cnt_nxt;
                        out_p1  <= onehot(cnt_nxt);
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    out_p1  <= '0;
                    busy_p1 <= 1'b0;
                    done_p1 <= 1'b0;
                end
            endcase
        end
    end

    assign OUT  = out_p1;
    assign BUSY = busy_p1;
    assign DONE = done_p1;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: default instance plus ADDR_W=3, ZERO_MASK=0.
module tb_decoder_scan;

    logic        clk;
    logic        rst;
    logic [4:0]  in_a;
    logic        en_a;
    logic        clr_a;
    logic [31:0] out_a;
    logic        busy_a;
    logic        done_a;

    logic [2:0]  in_b;
    logic        en_b;
    logic        clr_b;
    logic [7:0]  out_b;
    logic        busy_b;
    logic        done_b;

    int checks;
    int passes;

    decoder_scan dut_a (
        .CLK(clk), .RST(rst), .IN(in_a), .EN(en_a), .CLR_START(clr_a),
        .OUT(out_a), .BUSY(busy_a), .DONE(done_a)
    );

    decoder_scan #(.ADDR_W(3), .ZERO_MASK(0)) dut_b (
        .CLK(clk), .RST(rst), .IN(in_b), .EN(en_b), .CLR_START(clr_b),
        .OUT(out_b), .BUSY(busy_b), .DONE(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string name, input logic [31:0] o,
                         input logic b, input logic d);
        checks++;
        if (out_a !== o || busy_a !== b || done_a !== d)
            $display("FAIL %s: OUT=%h BUSY=%b DONE=%b, required OUT=%h BUSY=%b DONE=%b",
                     name, out_a, busy_a, done_a, o, b, d);
        else
            passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({out_a, busy_a, done_a} !== 34'h0)
            $display("FAIL reset_a: OUT=%h BUSY=%b DONE=%b, required all zero", out_a, busy_a, done_a);
        else passes++;
        checks++;
        if ({out_b, busy_b, done_b} !== 10'h0)
            $display("FAIL reset_b: OUT=%h BUSY=%b DONE=%b, required all zero", out_b, busy_b, done_b);
        else passes++;
        rst = 1'b0;
    endtask

    task automatic test_decode();
        en_a = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_a = 5'(i);
            tick();
            chk_a($sformatf("decode_%0d", i), (i == 0) ? 32'h0 : (32'h1 << i), 1'b0, 1'b0);
        end
    endtask

    task automatic test_enable();
        en_a = 1'b0;
        in_a = 5'd7;
        tick();
        chk_a("enable_off", 32'h0, 1'b0, 1'b0);
        en_a = 1'b1;
        tick();
        chk_a("enable_on", 32'h80, 1'b0, 1'b0);
        en_a = 1'b0;
        tick();
    endtask

    task automatic test_scan();
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        for (int k = 1; k < 32; k++) begin
            chk_a($sformatf("scan_%0d", k), 32'h1 << k, 1'b1, 1'b0);
            tick();
        end
        chk_a("scan_done", 32'h0, 1'b0, 1'b1);
        tick();
        chk_a("scan_done_clear", 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_nomask();
        en_b  = 1'b0;
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out_b !== (8'h1 << k) || busy_b !== 1'b1)
                $display("FAIL nomask_scan_%0d: OUT=%h BUSY=%b, required OUT=%h BUSY=1",
                         k, out_b, busy_b, 8'h1 << k);
            else passes++;
            tick();
        end
        checks++;
        if (out_b !== 8'h0 || busy_b !== 1'b0 || done_b !== 1'b1)
            $display("FAIL nomask_done: OUT=%h BUSY=%b DONE=%b, required 00/0/1", out_b, busy_b, done_b);
        else passes++;
        en_b = 1'b1;
        in_b = 3'd0;
        tick();
        checks++;
        if (out_b !== 8'h01 || done_b !== 1'b0)
            $display("FAIL nomask_idx0: OUT=%h DONE=%b, required 01/0", out_b, done_b);
        else passes++;
        en_b = 1'b0;
    endtask

    task automatic test_mid_reset();
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        chk_a("midrst_cycle10", 32'h400, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_a("midrst_abort", 32'h0, 1'b0, 1'b0);
        tick();
        chk_a("midrst_no_done", 32'h0, 1'b0, 1'b0);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk_a("midrst_restart", 32'h2, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_simultaneous();
        int  busy_cnt;
        logic saw_done;
        clr_a = 1'b1;
        en_a  = 1'b1;
        in_a  = 5'd9;
        tick();
        clr_a = 1'b0;
        chk_a("simul_scan_wins", 32'h2, 1'b1, 1'b0);
        busy_cnt = 1;
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            clr_a = (c == 5);
            tick();
            if (busy_a) busy_cnt++;
            else begin
                saw_done = done_a;
                break;
            end
        end
        clr_a = 1'b0;
        checks++;
        if (busy_cnt !== 31 || saw_done !== 1'b1)
            $display("FAIL simul_len: busy cycles=%0d done=%b, required 31/1", busy_cnt, saw_done);
        else passes++;
        en_a = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        clr_a = 1'b1;
        tick();
        chk_a("b2b_first", 32'h2, 1'b1, 1'b0);
        for (int k = 2; k < 32; k++) tick();
        chk_a("b2b_last", 32'h8000_0000, 1'b1, 1'b0);
        tick();
        chk_a("b2b_done", 32'h0, 1'b0, 1'b1);
        tick();
        chk_a("b2b_restart", 32'h2, 1'b1, 1'b0);
        clr_a = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b1;
        in_a = '0; en_a = 1'b0; clr_a = 1'b0;
        in_b = '0; en_b = 1'b0; clr_b = 1'b0;
        test_reset();
        test_decode();
        test_enable();
        test_scan();
        test_nomask();
        test_mid_reset();
        test_simultaneous();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: select-input width; output width is 2**ADDR_W.
REQ-002 SHALL have parameter ZERO_MASK, default 1: when 1, OUT[0] is never asserted (RISC-V x0 hardwired zero).
REQ-003 SHALL have port CLK  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port IN  input  ADDR_W: address to decode in normal mode.
REQ-006 SHALL have port EN  input  1: decode enable in normal mode.
REQ-007 SHALL have port CLR_START  input  1: request a full scan of all outputs, e.g. register-file clear sequence.
REQ-008 SHALL have port OUT  output  2**ADDR_W: registered one-hot select, or all-zero.
REQ-009 SHALL have port BUSY  output  1: high while a scan is in progress.
REQ-010 SHALL have port DONE  output  1: one-cycle pulse when a scan completes.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (normal decode) and SCAN (sequential walk); a one-cycle DONE output follows SCAN exit.
REQ-012 SHALL, in IDLE with CLR_START=0, register OUT on each edge as onehot(IN) if EN=1, else all-zero; latency is 1 cycle from input to OUT.
REQ-013 SHALL, in IDLE with EN=1, ZERO_MASK=1 and IN=0, drive OUT all-zero on the next cycle.
REQ-014 SHALL guarantee OUT is always either all-zero or exactly one bit high; no other value is legal.
REQ-015 SHALL define FIRST as 1 if ZERO_MASK=1, else 0, and LAST as 2**ADDR_W-1.
REQ-016 SHALL, on an edge in IDLE with CLR_START=1, enter SCAN and set OUT=onehot(FIRST) and BUSY=1; CLR_START takes priority over EN/IN on that edge.
REQ-017 SHALL, on each edge in SCAN while OUT≠onehot(LAST), advance OUT to the next index (one-hot shifts up by one bit); IN, EN and CLR_START are ignored.
REQ-018 SHALL, on the edge in SCAN where OUT=onehot(LAST), set OUT=0, BUSY=0 and DONE=1, and return to IDLE.
REQ-019 SHALL hold DONE high for exactly one cycle; inputs are sampled normally on the edge ending the DONE cycle.
REQ-020 SHALL keep BUSY high for exactly LAST-FIRST+1 cycles per scan: 31 cycles for the defaults, 32 cycles with ZERO_MASK=0.
REQ-021 SHALL ignore CLR_START asserted during SCAN; it neither restarts nor extends the scan.
REQ-022 SHALL size the internal scan counter to ADDR_W bits; the counter does not wrap past LAST.
REQ-023 SHALL accept CLR_START held high continuously, giving back-to-back scans separated by exactly one DONE cycle.

Reset
REQ-024 SHALL, on an edge with RST=1, force IDLE, OUT=0, BUSY=0, DONE=0 and counter=0, with priority over all other inputs.
REQ-025 SHALL abort a scan when RST is asserted mid-scan, with no DONE pulse; the next CLR_START restarts the scan from FIRST.

Verification
REQ-026 SHALL pass a normal-decode test: defaults, EN=1, IN stepping 0..31 one value per cycle -> OUT is 0 for IN=0, then 32'h2, 32'h4 ... 32'h8000_0000, each one cycle after IN changes.
REQ-027 SHALL pass an enable test: EN=0, IN=5'd7 -> OUT=0; then EN=1 -> OUT=32'h80 on the next cycle.
REQ-028 SHALL pass a full-scan test: defaults, 1-cycle CLR_START pulse -> OUT walks 32'h2..32'h8000_0000 over 31 cycles with BUSY=1, then OUT=0, BUSY=0, DONE=1 for 1 cycle.
REQ-029 SHALL pass a ZERO_MASK=0, ADDR_W=3 test: CLR_START -> OUT walks 8'h01..8'h80 over 8 cycles; EN=1, IN=0 in IDLE -> OUT=8'h01.
REQ-030 SHALL pass a mid-scan reset test: RST=1 at scan cycle 10 -> next cycle OUT=0, BUSY=0, DONE=0; a following CLR_START -> OUT=32'h2.
REQ-031 SHALL pass a simultaneous-input test: CLR_START=1 with EN=1, IN=5'd9 in IDLE -> OUT=32'h2 (scan wins); CLR_START pulsed mid-scan -> scan length unchanged at 31.
